// File: rtl/udt_rx_pkt_classifier.sv
// rtl/udt_rx_pkt_classifier.sv - UDT header parser splitting UDP payload into data/control body streams
// Strips the 16-byte big-endian UDT header and forwards the body with decoded header sidebands.
module udt_rx_pkt_classifier #(
   parameter int CNT_W = 32
) (
   input  logic             core_clk,
   input  logic             core_rst_n,
   input  logic             cfg_sock_filter_en,
   input  logic [31:0]      cfg_sock_id,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   input  logic             s_axis_tlast,
   input  logic [63:0]      s_axis_tdata,
   input  logic [7:0]       s_axis_tkeep,
   output logic             m_data_tvalid,
   input  logic             m_data_tready,
   output logic             m_data_tlast,
   output logic [63:0]      m_data_tdata,
   output logic [7:0]       m_data_tkeep,
   output logic [30:0]      m_data_seq,
   output logic [1:0]       m_data_ff,
   output logic             m_data_order,
   output logic [28:0]      m_data_msgno,
   output logic [31:0]      m_data_ts,
   output logic             m_ctrl_tvalid,
   input  logic             m_ctrl_tready,
   output logic             m_ctrl_tlast,
   output logic [63:0]      m_ctrl_tdata,
   output logic [7:0]       m_ctrl_tkeep,
   output logic [14:0]      m_ctrl_type,
   output logic [31:0]      m_ctrl_info,
   output logic [31:0]      m_ctrl_ts,
   output logic [CNT_W-1:0] cnt_data,
   output logic [CNT_W-1:0] cnt_ctrl,
   output logic [CNT_W-1:0] cnt_drop
);

   typedef enum logic [1:0] {ST_HDR0, ST_HDR1, ST_PAY, ST_DROP} state_t;

   state_t      state, state_nxt;
   logic [31:0] w0_q, w1_q;
   logic [31:0] beat_lo, beat_hi;
   logic        tgt_ctrl, tgt_free;
   logic        latch_b0, hdr_acc, fwd_beat, emit_empty;
   logic        inc_data, inc_ctrl, inc_drop;
   logic        load_data, load_ctrl;

   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   // Wire byte 0 is the most significant byte of each header word.
   assign beat_lo  = bswap(s_axis_tdata[31:0]);
   assign beat_hi  = bswap(s_axis_tdata[63:32]);
   assign tgt_ctrl = w0_q[31];
   assign tgt_free = tgt_ctrl ? (!m_ctrl_tvalid || m_ctrl_tready)
                              : (!m_data_tvalid || m_data_tready);

   always_ff @(posedge core_clk) begin
      if (!core_rst_n) begin
         state <= ST_HDR0;
         w0_q  <= '0;
         w1_q  <= '0;
      end else begin
         state <= state_nxt;
         if (latch_b0) begin
            w0_q <= beat_lo;
            w1_q <= beat_hi;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      s_axis_tready = 1'b0;
      latch_b0      = 1'b0;
      hdr_acc       = 1'b0;
      fwd_beat      = 1'b0;
      emit_empty    = 1'b0;
      inc_data      = 1'b0;
      inc_ctrl      = 1'b0;
      inc_drop      = 1'b0;
      case (state)
         ST_HDR0: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               if (s_axis_tlast || s_axis_tkeep != 8'hFF) begin
                  inc_drop  = 1'b1;
                  state_nxt = s_axis_tlast ? ST_HDR0 : ST_DROP;
               end else begin
                  latch_b0  = 1'b1;
                  state_nxt = ST_HDR1;
               end
            end
         end
         ST_HDR1: begin
            s_axis_tready = tgt_free;
            if (s_axis_tvalid && tgt_free) begin
               if (s_axis_tkeep != 8'hFF ||
                   (cfg_sock_filter_en && beat_hi != cfg_sock_id)) begin
                  inc_drop  = 1'b1;
                  state_nxt = s_axis_tlast ? ST_HDR0 : ST_DROP;
               end else begin
                  hdr_acc    = 1'b1;
                  inc_ctrl   = tgt_ctrl;
                  inc_data   = !tgt_ctrl;
                  emit_empty = s_axis_tlast;
                  state_nxt  = s_axis_tlast ? ST_HDR0 : ST_PAY;
               end
            end
         end
         ST_PAY: begin
            s_axis_tready = tgt_free;
            if (s_axis_tvalid && tgt_free) begin
               fwd_beat = 1'b1;
               if (s_axis_tlast) state_nxt = ST_HDR0;
            end
         end
         default: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) state_nxt = ST_HDR0;
         end
      endcase
   end

   assign load_data = (fwd_beat || emit_empty) && !tgt_ctrl;
   assign load_ctrl = (fwd_beat || emit_empty) && tgt_ctrl;

   always_ff @(posedge core_clk) begin
      if (!core_rst_n) begin
         m_data_tvalid <= 1'b0;
         m_data_tlast  <= 1'b0;
         m_data_tdata  <= '0;
         m_data_tkeep  <= '0;
         m_data_seq    <= '0;
         m_data_ff     <= '0;
         m_data_order  <= 1'b0;
         m_data_msgno  <= '0;
         m_data_ts     <= '0;
      end else begin
         if (load_data) begin
            m_data_tvalid <= 1'b1;
            m_data_tdata  <= emit_empty ? 64'd0 : s_axis_tdata;
            m_data_tkeep  <= emit_empty ? 8'h00 : s_axis_tkeep;
            m_data_tlast  <= emit_empty ? 1'b1 : s_axis_tlast;
         end else if (m_data_tready) begin
            m_data_tvalid <= 1'b0;
         end
         if (hdr_acc && !tgt_ctrl) begin
            m_data_seq   <= w0_q[30:0];
            m_data_ff    <= w1_q[31:30];
            m_data_order <= w1_q[29];
            m_data_msgno <= w1_q[28:0];
            m_data_ts    <= beat_lo;
         end
      end
   end

   always_ff @(posedge core_clk) begin
      if (!core_rst_n) begin
         m_ctrl_tvalid <= 1'b0;
         m_ctrl_tlast  <= 1'b0;
         m_ctrl_tdata  <= '0;
         m_ctrl_tkeep  <= '0;
         m_ctrl_type   <= '0;
         m_ctrl_info   <= '0;
         m_ctrl_ts     <= '0;
      end else begin
         if (load_ctrl) begin
            m_ctrl_tvalid <= 1'b1;
            m_ctrl_tdata  <= emit_empty ? 64'd0 : s_axis_tdata;
            m_ctrl_tkeep  <= emit_empty ? 8'h00 : s_axis_tkeep;
            m_ctrl_tlast  <= emit_empty ? 1'b1 : s_axis_tlast;
         end else if (m_ctrl_tready) begin
            m_ctrl_tvalid <= 1'b0;
         end
         if (hdr_acc && tgt_ctrl) begin
            m_ctrl_type <= w0_q[30:16];
            m_ctrl_info <= w1_q;
            m_ctrl_ts   <= beat_lo;
         end
      end
   end

   always_ff @(posedge core_clk) begin
      if (!core_rst_n) begin
         cnt_data <= '0;
         cnt_ctrl <= '0;
         cnt_drop <= '0;
      end else begin
         if (inc_data) cnt_data <= cnt_data + CNT_W'(1);
         if (inc_ctrl) cnt_ctrl <= cnt_ctrl + CNT_W'(1);
         if (inc_drop) cnt_drop <= cnt_drop + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_udt_rx_pkt_classifier.sv
// tb/tb_udt_rx_pkt_classifier.sv - directed self-checking bench for udt_rx_pkt_classifier
module tb_udt_rx_pkt_classifier;

   logic        core_clk = 1'b0;
   logic        core_rst_n = 1'b0;
   logic        cfg_sock_filter_en = 1'b0;
   logic [31:0] cfg_sock_id = 32'h0;
   logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
   logic [63:0] s_axis_tdata = '0;
   logic [7:0]  s_axis_tkeep = '0;
   logic        m_data_tvalid, m_data_tready = 1'b1, m_data_tlast;
   logic [63:0] m_data_tdata;
   logic [7:0]  m_data_tkeep;
   logic [30:0] m_data_seq;
   logic [1:0]  m_data_ff;
   logic        m_data_order;
   logic [28:0] m_data_msgno;
   logic [31:0] m_data_ts;
   logic        m_ctrl_tvalid, m_ctrl_tready = 1'b1, m_ctrl_tlast;
   logic [63:0] m_ctrl_tdata;
   logic [7:0]  m_ctrl_tkeep;
   logic [14:0] m_ctrl_type;
   logic [31:0] m_ctrl_info, m_ctrl_ts;
   logic [31:0] cnt_data, cnt_ctrl, cnt_drop;

   int n_chk = 0;
   int n_fail = 0;
   int out_ord = 0;

   logic [63:0] dq_d[$], cq_d[$];
   logic [7:0]  dq_k[$], cq_k[$];
   logic        dq_l[$], cq_l[$];
   int          dq_o[$], cq_o[$];

   udt_rx_pkt_classifier #(.CNT_W(32)) dut (
      .core_clk(core_clk), .core_rst_n(core_rst_n),
      .cfg_sock_filter_en(cfg_sock_filter_en), .cfg_sock_id(cfg_sock_id),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready), .m_data_tlast(m_data_tlast),
      .m_data_tdata(m_data_tdata), .m_data_tkeep(m_data_tkeep), .m_data_seq(m_data_seq),
      .m_data_ff(m_data_ff), .m_data_order(m_data_order), .m_data_msgno(m_data_msgno),
      .m_data_ts(m_data_ts),
      .m_ctrl_tvalid(m_ctrl_tvalid), .m_ctrl_tready(m_ctrl_tready), .m_ctrl_tlast(m_ctrl_tlast),
      .m_ctrl_tdata(m_ctrl_tdata), .m_ctrl_tkeep(m_ctrl_tkeep), .m_ctrl_type(m_ctrl_type),
      .m_ctrl_info(m_ctrl_info), .m_ctrl_ts(m_ctrl_ts),
      .cnt_data(cnt_data), .cnt_ctrl(cnt_ctrl), .cnt_drop(cnt_drop)
   );

   always #5 core_clk = ~core_clk;

   always @(negedge core_clk) begin
      if (core_rst_n && m_data_tvalid && m_data_tready) begin
         dq_d.push_back(m_data_tdata); dq_k.push_back(m_data_tkeep);
         dq_l.push_back(m_data_tlast); dq_o.push_back(out_ord);
         out_ord++;
      end
      if (core_rst_n && m_ctrl_tvalid && m_ctrl_tready) begin
         cq_d.push_back(m_ctrl_tdata); cq_k.push_back(m_ctrl_tkeep);
         cq_l.push_back(m_ctrl_tlast); cq_o.push_back(out_ord);
         out_ord++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   function automatic logic [63:0] mk(input logic [31:0] wa, input logic [31:0] wb);
      return {bswap(wb), bswap(wa)};
   endfunction

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
      int n = 0;
      s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
      @(negedge core_clk);
      while (!s_axis_tready && n < 200) begin
         @(negedge core_clk);
         n++;
      end
      if (n >= 200) begin
         n_chk++; n_fail++;
         $display("FAIL send_timeout: got tready=0 expected tready=1 within 200 clk");
      end
      @(posedge core_clk); #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge core_clk);
      #1;
   endtask

   task automatic clear_q();
      dq_d.delete(); dq_k.delete(); dq_l.delete(); dq_o.delete();
      cq_d.delete(); cq_k.delete(); cq_l.delete(); cq_o.delete();
   endtask

   initial begin
      idle(3);
      core_rst_n = 1'b1;
      #1;
      check("rst_data_tvalid", m_data_tvalid, 0);
      check("rst_ctrl_tvalid", m_ctrl_tvalid, 0);
      check("rst_cnt_data", cnt_data, 0);
      check("rst_cnt_drop", cnt_drop, 0);
      check("rst_s_tready", s_axis_tready, 1);

      // 1: data packet with three body beats
      send_beat(mk(32'h0000_0005, 32'h8000_0007), 8'hFF, 0);
      send_beat(mk(32'h0000_0011, 32'hABCD_0001), 8'hFF, 0);
      send_beat(64'h1111_2222_3333_4444, 8'hFF, 0);
      send_beat(64'h5555_6666_7777_8888, 8'hFF, 0);
      send_beat(64'h0000_0000_00AB_CDEF, 8'h07, 1);
      idle(3);
      check("t1_nbeats", dq_d.size(), 3);
      if (dq_d.size() == 3) begin
         check("t1_b0", dq_d[0], 64'h1111_2222_3333_4444);
         check("t1_b1", dq_d[1], 64'h5555_6666_7777_8888);
         check("t1_b2", dq_d[2], 64'h0000_0000_00AB_CDEF);
         check("t1_k2", dq_k[2], 8'h07);
         check("t1_l", {dq_l[0], dq_l[1], dq_l[2]}, 3'b001);
      end
      check("t1_seq", m_data_seq, 5);
      check("t1_ff", m_data_ff, 2);
      check("t1_order", m_data_order, 0);
      check("t1_msgno", m_data_msgno, 7);
      check("t1_ts", m_data_ts, 32'h11);
      check("t1_cnt_data", cnt_data, 1);
      check("t1_ctrl_none", cq_d.size(), 0);
      clear_q();

      // 2: header-only control packet
      send_beat(mk(32'h8006_0000, 32'h0000_002A), 8'hFF, 0);
      send_beat(mk(32'h0000_0055, 32'h0), 8'hFF, 1);
      idle(3);
      check("t2_nbeats", cq_d.size(), 1);
      if (cq_d.size() == 1) begin
         check("t2_data", cq_d[0], 0);
         check("t2_keep", cq_k[0], 0);
         check("t2_last", cq_l[0], 1);
      end
      check("t2_type", m_ctrl_type, 6);
      check("t2_info", m_ctrl_info, 32'h2A);
      check("t2_ts", m_ctrl_ts, 32'h55);
      check("t2_cnt_ctrl", cnt_ctrl, 1);
      clear_q();

      // 3: 12-byte runt, then 8-byte runt
      send_beat(mk(32'h0000_0001, 32'h0), 8'hFF, 0);
      send_beat(64'h0000_0000_1234_5678, 8'h0F, 1);
      idle(2);
      check("t3_drop1", cnt_drop, 1);
      send_beat(mk(32'h0000_0002, 32'h0), 8'hFF, 1);
      idle(2);
      check("t3_drop2", cnt_drop, 2);
      check("t3_no_out", dq_d.size() + cq_d.size(), 0);

      // 4: socket filter rejects then accepts
      cfg_sock_filter_en = 1'b1; cfg_sock_id = 32'h0000_1234;
      send_beat(mk(32'h0000_0009, 32'h4000_0001), 8'hFF, 0);
      send_beat(mk(32'h0000_0022, 32'h0000_9999), 8'hFF, 0);
      send_beat(64'hA, 8'hFF, 0);
      send_beat(64'hB, 8'hFF, 0);
      send_beat(64'hC, 8'hFF, 1);
      idle(2);
      check("t4_drop", cnt_drop, 3);
      check("t4_no_out", dq_d.size() + cq_d.size(), 0);
      send_beat(mk(32'h0000_000A, 32'hC000_0003), 8'hFF, 0);
      send_beat(mk(32'h0000_0033, 32'h0000_1234), 8'hFF, 0);
      send_beat(64'hDEAD_BEEF_0000_0001, 8'h3F, 1);
      idle(3);
      check("t4_pass_n", dq_d.size(), 1);
      if (dq_d.size() == 1) check("t4_pass_d", dq_d[0], 64'hDEAD_BEEF_0000_0001);
      check("t4_seq", m_data_seq, 10);
      check("t4_ff", m_data_ff, 3);
      check("t4_msgno", m_data_msgno, 3);
      check("t4_cnt_data", cnt_data, 2);
      cfg_sock_filter_en = 1'b0;
      clear_q();

      // 5: data then ctrl while the data sink stalls for 10 clocks
      m_data_tready = 1'b0;
      fork
         begin
            send_beat(mk(32'h0000_0014, 32'h2000_0004), 8'hFF, 0);
            send_beat(mk(32'h0000_0066, 32'h0), 8'hFF, 0);
            send_beat(64'hD1, 8'hFF, 0);
            send_beat(64'hD2, 8'hFF, 1);
            send_beat(mk(32'h8002_0000, 32'h0000_0077), 8'hFF, 0);
            send_beat(mk(32'h0000_0044, 32'h0), 8'hFF, 0);
            send_beat(64'hC1, 8'h03, 1);
         end
         begin
            idle(10);
            check("t5_ctrl_held", cq_d.size(), 0);
            m_data_tready = 1'b1;
         end
      join
      idle(3);
      check("t5_data_n", dq_d.size(), 2);
      check("t5_ctrl_n", cq_d.size(), 1);
      if (dq_d.size() == 2 && cq_d.size() == 1) begin
         check("t5_d1", dq_d[0], 64'hD1);
         check("t5_d2", dq_d[1], 64'hD2);
         check("t5_c1", cq_d[0], 64'hC1);
         check("t5_c1_keep", cq_k[0], 8'h03);
         check("t5_order", cq_o[0] > dq_o[1], 1);
      end
      check("t5_msgno", m_data_msgno, 4);
      check("t5_order_bit", m_data_order, 1);
      check("t5_ctrl_type", m_ctrl_type, 2);
      check("t5_cnt_data", cnt_data, 3);
      check("t5_cnt_ctrl", cnt_ctrl, 2);
      clear_q();

      // 6: reset mid-body, then a fresh packet
      m_data_tready = 1'b0;
      send_beat(mk(32'h0000_0030, 32'h0), 8'hFF, 0);
      send_beat(mk(32'h0000_0031, 32'h0), 8'hFF, 0);
      send_beat(64'hEE, 8'hFF, 0);
      check("t6_pre_valid", m_data_tvalid, 1);
      core_rst_n = 1'b0;
      idle(1);
      core_rst_n = 1'b1;
      check("t6_tvalid", m_data_tvalid, 0);
      check("t6_cnt_data", cnt_data, 0);
      check("t6_cnt_ctrl", cnt_ctrl, 0);
      check("t6_cnt_drop", cnt_drop, 0);
      check("t6_seq", m_data_seq, 0);
      m_data_tready = 1'b1;
      clear_q();
      send_beat(mk(32'h8005_0000, 32'h0000_0099), 8'hFF, 0);
      send_beat(mk(32'h0000_0007, 32'h0), 8'hFF, 1);
      idle(3);
      check("t6_ctrl_n", cq_d.size(), 1);
      check("t6_type", m_ctrl_type, 5);
      check("t6_info", m_ctrl_info, 32'h99);
      check("t6_cnt_ctrl_after", cnt_ctrl, 1);
      check("t6_data_none", dq_d.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
